// File: rtl/vpu_pal_arbiter.sv
// vpu_pal_arbiter: shares the single-port palette RAM between the BG palette
// stage (absolute priority, never stalled), the sprite palette stage and the
// CPU bus. Sprite and CPU split the cycles BG leaves free, round-robin.
module vpu_pal_arbiter #(
  parameter int PAL_ADDR_W = 10,
  parameter int PAL_DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // BG pipeline palette stage
  input  logic                  bg_en,
  input  logic [PAL_ADDR_W-1:0] bg_addr,
  output logic [PAL_DATA_W-1:0] bg_dout,
  // sprite pipeline palette stage
  input  logic                  sp_req,
  input  logic [PAL_ADDR_W-1:0] sp_addr,
  output logic                  sp_gnt,
  output logic                  sp_rvalid,
  output logic [PAL_DATA_W-1:0] sp_rdata,
  // CPU bus
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [PAL_ADDR_W-1:0] cpu_addr,
  input  logic [PAL_DATA_W-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_ack,
  output logic [PAL_DATA_W-1:0] cpu_rdata,
  // palette RAM macro
  output logic                  pal_en,
  output logic                  pal_we,
  output logic [PAL_ADDR_W-1:0] pal_addr,
  output logic [PAL_DATA_W-1:0] pal_din,
  input  logic [PAL_DATA_W-1:0] pal_dout
);

  // CPU transaction FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // owner of the previous cycle's read (selects the read-data consumer)
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_BG   = 2'd1;
  localparam logic [1:0] OWN_SP   = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  // last winner of a sprite/CPU tie-break
  localparam logic RR_SP  = 1'b0;
  localparam logic RR_CPU = 1'b1;

  logic [1:0]            state_q, state_d;
  logic [1:0]            owner_q, owner_d;
  logic                  rr_last_q, rr_last_d;
  logic                  cpu_we_q;
  logic [PAL_ADDR_W-1:0] cpu_addr_q;
  logic [PAL_DATA_W-1:0] cpu_wdata_q;
  logic [PAL_DATA_W-1:0] cpu_rdata_q;

  logic cpu_pend;
  logic cpu_accept;
  logic sp_win;
  logic bg_sel;
  logic sp_sel;
  logic cpu_sel;

  assign cpu_pend   = (state_q == ST_PEND);
  assign cpu_accept = (state_q == ST_IDLE) && cpu_req;

  // Slot arbitration: BG first, then sprite/CPU by round-robin. Grants are
  // masked during reset so the RAM port goes quiet asynchronously.
  always_comb begin
    sp_win  = sp_req && (!cpu_pend || (rr_last_q == RR_CPU));
    bg_sel  = !rst && bg_en;
    sp_sel  = !rst && !bg_en && sp_win;
    cpu_sel = !rst && !bg_en && cpu_pend && !sp_win;
  end

  // Next-state for the FSM, the round-robin pointer and the read owner.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and infers a latch.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = OWN_NONE;

    case (state_q)
      ST_IDLE: if (cpu_req) state_d = ST_PEND;
      ST_PEND: if (cpu_sel) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (sp_sel)       rr_last_d = RR_SP;
    else if (cpu_sel) rr_last_d = RR_CPU;

    if (bg_sel)                    owner_d = OWN_BG;
    else if (sp_sel)               owner_d = OWN_SP;
    else if (cpu_sel && !cpu_we_q) owner_d = OWN_CPU;
  end

  // Control state: FSM, read owner and round-robin pointer.
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      rr_last_q <= RR_CPU;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Latch the CPU transaction on acceptance; capture read data at the ack.
  // NOTE: these are plain registers, not a memory array, so they are reset to
  // keep cpu_rdata at a defined 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (cpu_accept) begin
        cpu_we_q    <= cpu_we;
        cpu_addr_q  <= cpu_addr;
        cpu_wdata_q <= cpu_wdata;
      end
      if ((state_q == ST_DONE) && !cpu_we_q) begin
        cpu_rdata_q <= pal_dout;
      end
    end
  end

  // RAM port drive
  assign pal_en   = bg_sel || sp_sel || cpu_sel;
  assign pal_we   = cpu_sel && cpu_we_q;
  assign pal_addr = bg_sel ? bg_addr : (sp_sel ? sp_addr : cpu_addr_q);
  assign pal_din  = cpu_wdata_q;

  // Requester handshakes and return routing
  assign bg_dout   = pal_dout;
  assign sp_gnt    = sp_sel;
  assign sp_rvalid = (owner_q == OWN_SP);
  assign sp_rdata  = pal_dout;
  assign cpu_ready = (state_q == ST_IDLE);
  assign cpu_ack   = (state_q == ST_DONE);
  // the live RAM word is presented during the ack, the captured copy after it
  assign cpu_rdata = (cpu_ack && !cpu_we_q) ? pal_dout : cpu_rdata_q;

endmodule

// File: tb/tb_vpu_pal_arbiter.sv
// Bench for vpu_pal_arbiter: a behavioural one-cycle-latency palette RAM, a
// shadow copy of its expected contents, and scoreboards for sprite and CPU
// read data.
module tb_vpu_pal_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bg_en = 1'b0;
  logic [AW-1:0] bg_addr = '0;
  logic [DW-1:0] bg_dout;
  logic          sp_req = 1'b0;
  logic [AW-1:0] sp_addr = '0;
  logic          sp_gnt;
  logic          sp_rvalid;
  logic [DW-1:0] sp_rdata;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          pal_en;
  logic          pal_we;
  logic [AW-1:0] pal_addr;
  logic [DW-1:0] pal_din;
  logic [DW-1:0] pal_dout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
  } cpu_exp_t;

  cpu_exp_t      cpu_q[$];
  logic [DW-1:0] sp_q[$];
  logic [DW-1:0] ram[1 << AW];
  logic [DW-1:0] shadow[1 << AW];

  always #5 clk = ~clk;

  vpu_pal_arbiter #(.PAL_ADDR_W(AW), .PAL_DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .bg_en(bg_en), .bg_addr(bg_addr), .bg_dout(bg_dout),
    .sp_req(sp_req), .sp_addr(sp_addr), .sp_gnt(sp_gnt),
    .sp_rvalid(sp_rvalid), .sp_rdata(sp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .pal_en(pal_en), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_din(pal_din), .pal_dout(pal_dout)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // palette RAM macro: one-cycle read latency, write lands at the edge
  always @(posedge clk) begin
    if (pal_en) begin
      if (pal_we) ram[pal_addr] <= pal_din;
      else        pal_dout      <= ram[pal_addr];
    end
  end

  // sprite scoreboard: push on grant, pop on valid
  initial begin
    logic          prev_gnt;
    logic [DW-1:0] exp_d;
    prev_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sp_q.delete();
        prev_gnt = 1'b0;
      end else begin
        n_checks++;
        if (sp_rvalid !== prev_gnt) begin
          n_fail++;
          $display("FAIL sp_rvalid_timing @%0t: got %b expected %b", $time, sp_rvalid, prev_gnt);
        end
        if (sp_rvalid === 1'b1 || prev_gnt) begin
          if (sp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sp_rdata_unexpected @%0t: got %h with nothing expected", $time, sp_rdata);
          end else begin
            exp_d = sp_q.pop_front();
            if (sp_rvalid === 1'b1) begin
              n_checks++;
              if (sp_rdata !== exp_d) begin
                n_fail++;
                $display("FAIL sp_rdata @%0t: got %h expected %h", $time, sp_rdata, exp_d);
              end
            end
          end
        end
        prev_gnt = (sp_gnt === 1'b1);
        if (sp_gnt === 1'b1) sp_q.push_back(shadow[sp_addr]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present a CPU transaction until accepted; record the expected outcome
  task automatic cpu_accept(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic     ok;
    cpu_exp_t e;
    ok = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = (cpu_ready === 1'b1);
      step();
    end
    cpu_req = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cpu_accept_timeout: got ready=0 expected ready=1 within 100 cycles");
    end else begin
      if (we) shadow[a] = d;
      e.we   = we;
      e.data = shadow[a];
      cpu_q.push_back(e);
    end
  endtask

  // wait for cpu_ack, check read data against the scoreboard, return latency
  task automatic cpu_wait_ack(input int bound, output int lat);
    logic     got;
    cpu_exp_t e;
    got = 1'b0;
    lat = 0;
    while (lat < bound && !got) begin
      @(negedge clk);
      lat++;
      got = (cpu_ack === 1'b1);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL cpu_ack_timeout: got no ack expected ack within %0d cycles", bound);
    end else if (cpu_q.size() == 0) begin
      n_fail++;
      $display("FAIL cpu_ack_unexpected: got ack expected none");
    end else begin
      e = cpu_q.pop_front();
      if (!e.we && cpu_rdata !== e.data) begin
        n_fail++;
        $display("FAIL cpu_rdata: got %h expected %h", cpu_rdata, e.data);
      end
    end
    step();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({cpu_ready, cpu_ack, sp_rvalid, pal_en, pal_we} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/ack/rv/en/we=%b expected 10000",
               {cpu_ready, cpu_ack, sp_rvalid, pal_en, pal_we});
    end
    n_checks++;
    if (cpu_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b1 || pal_en !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got ready=%b en=%b expected ready=1 en=0", cpu_ready, pal_en);
    end
    step();
  endtask

  task automatic test_cpu_write_read();
    int lat;
    cpu_accept(1'b1, 10'h012, 32'hFF00_FF00);
    cpu_wait_ack(20, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL write_latency: got %0d expected 2", lat); end
    cpu_accept(1'b0, 10'h012, '0);
    cpu_wait_ack(20, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL read_latency: got %0d expected 2", lat); end
    cpu_accept(1'b0, 10'h3A0, '0);
    cpu_wait_ack(20, lat);
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== pat(10'h3A0)) begin
      n_fail++;
      $display("FAIL cpu_rdata_hold: got ack=%b data=%h expected ack=0 data=%h", cpu_ack, cpu_rdata, pat(10'h3A0));
    end
    step();
  endtask

  task automatic test_round_robin();
    cpu_exp_t e;
    rst = 1'b1;
    sp_req = 1'b1; sp_addr = 10'h012;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h055;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sp_gnt !== 1'b1 || cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_first_sp: got gnt=%b ready=%b expected 1 1", sp_gnt, cpu_ready);
    end
    e.we = 1'b0; e.data = shadow[10'h055];
    cpu_q.push_back(e);
    step();
    sp_addr = 10'h013;
    @(negedge clk);
    n_checks++;
    if (sp_gnt !== 1'b0 || pal_en !== 1'b1 || pal_we !== 1'b0 || pal_addr !== 10'h055) begin
      n_fail++;
      $display("FAIL rr_second_cpu: got gnt=%b en=%b we=%b addr=%h expected 0 1 0 055",
               sp_gnt, pal_en, pal_we, pal_addr);
    end
    step();
    sp_addr = 10'h014;
    @(negedge clk);
    n_checks++;
    if (sp_gnt !== 1'b1 || cpu_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_third_sp: got gnt=%b ack=%b expected 1 1", sp_gnt, cpu_ack);
    end
    e = cpu_q.pop_front();
    n_checks++;
    if (cpu_rdata !== e.data) begin
      n_fail++;
      $display("FAIL rr_cpu_rdata: got %h expected %h", cpu_rdata, e.data);
    end
    step();
    cpu_req = 1'b0; sp_req = 1'b0;
    step();
  endtask

  task automatic test_bg_priority();
    int            lat;
    logic [DW-1:0] bg_exp;
    logic          bg_exp_v;
    bg_exp_v = 1'b0;
    bg_exp   = '0;
    bg_en = 1'b1; bg_addr = '0;
    sp_req = 1'b1; sp_addr = 10'h100;
    cpu_accept(1'b0, 10'h200, '0);
    for (int i = 0; i < 1280; i++) begin
      @(negedge clk);
      n_checks++;
      if (sp_gnt !== 1'b0 || cpu_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL bg_blocks_others @%0d: got gnt=%b ack=%b expected 0 0", i, sp_gnt, cpu_ack);
      end
      if (bg_exp_v) begin
        n_checks++;
        if (bg_dout !== bg_exp) begin
          n_fail++;
          $display("FAIL bg_dout @%0d: got %h expected %h", i, bg_dout, bg_exp);
        end
      end
      bg_exp   = shadow[bg_addr];
      bg_exp_v = 1'b1;
      step();
      bg_addr = bg_addr + 10'd7;
    end
    bg_en = 1'b0; sp_req = 1'b0;
    cpu_wait_ack(20, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL bg_release_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_hblank_drain();
    cpu_exp_t e;
    bg_en = 1'b1; sp_req = 1'b0; bg_addr = 10'h040;
    cpu_accept(1'b0, 10'h321, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_ack !== 1'b0 || cpu_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hblank_pend: got ack=%b ready=%b expected 0 0", cpu_ack, cpu_ready);
      end
      step();
    end
    bg_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pal_en !== 1'b1 || pal_we !== 1'b0 || pal_addr !== 10'h321 || cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL hblank_grant_T: got en=%b we=%b addr=%h ack=%b expected 1 0 321 0",
               pal_en, pal_we, pal_addr, cpu_ack);
    end
    step();
    @(negedge clk);
    e = cpu_q.pop_front();
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_ready !== 1'b0 || cpu_rdata !== e.data) begin
      n_fail++;
      $display("FAIL hblank_ack_T1: got ack=%b ready=%b data=%h expected 1 0 %h",
               cpu_ack, cpu_ready, cpu_rdata, e.data);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL hblank_ready_T2: got ready=%b ack=%b expected 1 0", cpu_ready, cpu_ack);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    // sprite read in flight: its valid must vanish on reset
    sp_req = 1'b1; sp_addr = 10'h005;
    step();
    sp_req = 1'b0;
    n_checks++;
    if (sp_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL sp_inflight: got rvalid=%b expected 1", sp_rvalid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (sp_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL sp_reset_discard: got rvalid=%b expected 0", sp_rvalid);
    end
    step();
    rst = 1'b0;
    step();
    // CPU read stuck in PEND behind BG, then reset
    bg_en = 1'b1;
    cpu_accept(1'b0, 10'h0AB, '0);
    #2;
    rst = 1'b1;
    #1;
    cpu_q.delete();
    n_checks++;
    if (cpu_ready !== 1'b1 || pal_en !== 1'b0 || pal_we !== 1'b0 || cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got ready=%b en=%b we=%b ack=%b expected 1 0 0 0",
               cpu_ready, pal_en, pal_we, cpu_ack);
    end
    step();
    rst = 1'b0; bg_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_ack !== 1'b0 || pal_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_dropped: got ack=%b en=%b expected 0 0", cpu_ack, pal_en);
      end
      step();
    end
    cpu_accept(1'b1, 10'h0AB, 32'h1234_5678);
    cpu_wait_ack(20, lat);
    cpu_accept(1'b0, 10'h0AB, '0);
    cpu_wait_ack(20, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_sprite_bg_gaps();
    sp_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bg_en   = (i % 2) == 1;
      bg_addr = 10'(i * 3);
      if (i == 4)      sp_addr = 10'h012;
      else if (i == 6) sp_addr = 10'h0AB;
      else             sp_addr = 10'(i * 37);
      @(negedge clk);
      n_checks++;
      if (sp_gnt !== !bg_en) begin
        n_fail++;
        $display("FAIL sp_gap_gnt @%0d: got %b expected %b", i, sp_gnt, !bg_en);
      end
      step();
    end
    sp_req = 1'b0; bg_en = 1'b0;
    step();
    step();
    n_checks++;
    if (sp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sp_drain: got %0d outstanding expected 0", sp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = pat(i);
      shadow[i] = pat(i);
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_cpu_write_read();
    test_round_robin();
    test_bg_priority();
    test_hblank_drain();
    test_reset_mid();
    test_sprite_bg_gaps();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vpu_pal_arbiter.md
# vpu_pal_arbiter

Shares the single-port palette RAM between three requesters: the BG pipeline palette stage, the sprite pipeline palette stage, and the CPU bus. The BG stage has absolute priority and is never stalled. The sprite stage and the CPU split the leftover cycles round-robin. The block sits between the VPU pipelines and the palette RAM macro, replaces the direct `pal_en`/`pal_addr` hookup, and is the only path through which the CPU reads or writes the palette.

## Interface

Parameters:
- `PAL_ADDR_W`, 10, palette RAM address width (word address).
- `PAL_DATA_W`, 32, palette entry width (ARGB8888).

Ports:
- `clk`  in  1  system clock; the single clock for the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `bg_en`  in  1  BG palette read request, level, may be high every cycle.
- `bg_addr`  in  `PAL_ADDR_W`  BG read address.
- `bg_dout`  out  `PAL_DATA_W`  BG read data, one cycle after `bg_en`.
- `sp_req`  in  1  sprite read request, level.
- `sp_addr`  in  `PAL_ADDR_W`  sprite read address.
- `sp_gnt`  out  1  combinational grant; the request is issued this cycle.
- `sp_rvalid`  out  1  sprite read data valid, one cycle after `sp_gnt`.
- `sp_rdata`  out  `PAL_DATA_W`  sprite read data.
- `cpu_req`  in  1  CPU transaction request.
- `cpu_we`  in  1  1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_addr`  in  `PAL_ADDR_W`  CPU address.
- `cpu_wdata`  in  `PAL_DATA_W`  CPU write data.
- `cpu_ready`  out  1  CPU transaction slot free; accept when `cpu_req && cpu_ready`.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  `PAL_DATA_W`  read data, valid only with `cpu_ack` for reads.
- `pal_en`  out  1  RAM enable.
- `pal_we`  out  1  RAM write enable.
- `pal_addr`  out  `PAL_ADDR_W`  RAM address.
- `pal_din`  out  `PAL_DATA_W`  RAM write data.
- `pal_dout`  in  `PAL_DATA_W`  RAM read data, one-cycle read latency.

## Operation

- **Slot arbitration (combinational, every cycle):**
  - If `bg_en` is high, BG owns the port.
  - Otherwise the candidates are `sp_req` and a pending CPU transaction. If both are present, the winner is the one not granted last; the `rr_last` flop is updated only when a sp/CPU grant occurs. If only one is present, it wins.
  - If there is no requester, `pal_en` = 0.
- **Port drive:**
  - `pal_en` = 1 whenever any owner is selected.
  - `pal_we` = 1 only for a CPU write.
  - `pal_din` = the latched CPU wdata; it is don't-care otherwise.
- **CPU FSM:**
  - IDLE: `cpu_ready` = 1. On `cpu_req`, latch `we`/`addr`/`wdata` and go to PEND.
  - PEND: wait for a grant. On the grant cycle go to DONE.
  - DONE: `cpu_ack` = 1. For a read, `cpu_rdata` = `pal_dout`. Return to IDLE.
  - A new request is accepted no earlier than the cycle after the ack.
- **Return routing:**
  - Flop `owner_q` ∈ {NONE, BG, SP, CPU} records the previous cycle's owner (reads only).
  - `bg_dout` = `pal_dout` unconditionally. The BG stage ignores stale data.
  - `sp_rvalid` = (`owner_q` == SP). `sp_rdata` = `pal_dout`.
  - `cpu_rdata` is registered at the DONE cycle and holds until the next ack.
- **Reset (asynchronous):**
  - FSM = IDLE, `owner_q` = NONE, `rr_last` = CPU (so sprite wins the first tie).
  - Outputs: `cpu_ready` = 1, `cpu_ack` = 0, `sp_rvalid` = 0, `cpu_rdata` = 0, `pal_en` = 0, `pal_we` = 0.
- **Reset mid-transaction:** a latched CPU transaction is dropped with no ack. A pending RAM read result is discarded.

## Timing

- Sprite read latency: `sp_gnt` at cycle N, `sp_rvalid` and data at N+1. Back-to-back grants give back-to-back valids.
- CPU latency:
  - Minimum is 2 cycles from acceptance to `cpu_ack`: accept at N, grant at N+1, ack at N+2.
  - While `bg_en` is held high (visible region), the CPU stays in PEND indefinitely. There is no timeout; the CPU is expected to access during hblank/vblank.
- A CPU write lands in RAM at the grant edge. A sprite read of the same address granted in a later cycle returns the new value.
- A BG request arriving in the same cycle as a sprite/CPU request always wins. The loser holds and retries the next cycle; `sp_gnt` = 0 in that cycle.
- With the sprite and CPU both continuously requesting and BG idle, grants alternate SP, CPU, SP, CPU...

## Test plan

- **BG priority:** `bg_en` = 1 for 1280 cycles with `sp_req` = 1 and a CPU read pending → `sp_gnt` = 0 and `cpu_ack` = 0 throughout; `bg_dout` tracks the RAM contents at `bg_addr` one cycle later.
- **CPU write then read:** BG idle; write `addr` = 0x012, `wdata` = 0xFF00FF00 → `cpu_ack` 2 cycles after accept. Then a read of 0x012 → `cpu_ack` with `cpu_rdata` = 0xFF00FF00.
- **Round-robin:** BG idle, `sp_req` and CPU reads requested continuously from reset → the first grant goes to SP, then CPU, then SP; `sp_rvalid` follows each `sp_gnt` by exactly one cycle.
- **Hblank drain:** a CPU read is accepted while `bg_en` = 1. `bg_en` drops at cycle T → grant at T, `cpu_ack` at T+1; `cpu_ready` returns at T+2.
- **Reset mid-transaction:** assert `rst` while the CPU is in PEND → `cpu_ready` = 1 and `pal_en` = 0 asynchronously; no `cpu_ack` after release; the next transaction completes normally.
- **Sprite back-to-back with BG gaps:** `bg_en` toggles 1/0 each cycle with `sp_req` = 1 → `sp_gnt` is high only in the `bg_en` = 0 cycles, and the `sp_rdata` values match the sprite addresses.
